coin_vend_ctrl: RTL and testbench

//  Parametrised coin-accepting vending controller; next generation of the fixed
//  4-credit FSM. Adds configurable price and coin values, a queue of pending

---
 rtl/vend_pkg.sv | 16 +
 rtl/coin_vend_ctrl_if.sv | 27 ++
 rtl/coin_value_decode.sv | 25 ++
 rtl/coin_vend_ctrl.sv | 103 ++++++++++
 tb/tb_coin_vend_ctrl.sv | 128 ++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared types for the coin vending controller: coin encodings and FSM states.
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_NONE   = 2'b00,
    COIN_CIRCLE = 2'b01,
    COIN_TRI    = 2'b10,
    COIN_PENT   = 2'b11
  } coin_t;

  typedef enum logic {
    VS_IDLE = 1'b0,
    VS_VEND = 1'b1
  } vend_state_t;

endpackage

// File: rtl/coin_vend_ctrl_if.sv
// Coin acceptor / dispenser / refund signal bundle between the controller and its environment.
interface coin_vend_ctrl_if
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 4,
  parameter int PEND_W   = 2
);
  coin_t               coin;
  logic                cancel;
  logic                drop_ack;
  logic [CREDIT_W-1:0] credit;
  logic                drop;
  logic [PEND_W-1:0]   pending;
  logic                coin_reject;
  logic                refund_valid;
  logic [CREDIT_W-1:0] refund_amt;

  modport slave (
    input  coin, cancel, drop_ack,
    output credit, drop, pending, coin_reject, refund_valid, refund_amt
  );

  modport master (
    output coin, cancel, drop_ack,
    input  credit, drop, pending, coin_reject, refund_valid, refund_amt
  );
endinterface

// File: rtl/coin_value_decode.sv
// Maps an inserted coin to its credit value; one bit wider than the credit register
// so any legal coin value fits.
module coin_value_decode
  import vend_pkg::*;
#(
  parameter int CREDIT_W   = 4,
  parameter int VAL_CIRCLE = 1,
  parameter int VAL_TRI    = 3,
  parameter int VAL_PENT   = 5
) (
  input  coin_t             i_coin,
  output logic [CREDIT_W:0] o_val
);

  always_comb begin
    o_val = '0;
    case (i_coin)
      COIN_CIRCLE: o_val = (CREDIT_W+1)'(VAL_CIRCLE);
      COIN_TRI:    o_val = (CREDIT_W+1)'(VAL_TRI);
      COIN_PENT:   o_val = (CREDIT_W+1)'(VAL_PENT);
      default:     o_val = '0;
    endcase
  end

endmodule

// File: rtl/coin_vend_ctrl.sv
// Coin-accepting vending controller: credit accumulator, bounded queue of pending
// drops released by a dispenser handshake, coin rejection when full, refund on cancel.
module coin_vend_ctrl
  import vend_pkg::*;
#(
  parameter int CREDIT_W   = 4,
  parameter int PRICE      = 4,
  parameter int VAL_CIRCLE = 1,
  parameter int VAL_TRI    = 3,
  parameter int VAL_PENT   = 5,
  parameter int MAX_PEND   = 3,
  parameter int PEND_W     = $clog2(MAX_PEND + 1)
) (
  input  logic             clock,
  input  logic             reset,
  coin_vend_ctrl_if.slave  bus
);

  localparam logic [CREDIT_W:0] PRICE_X  = (CREDIT_W+1)'(PRICE);
  localparam logic [PEND_W-1:0] MAX_P    = PEND_W'(MAX_PEND);
  localparam logic [PEND_W-1:0] ONE_P    = PEND_W'(1);

  vend_state_t         r_state;
  vend_state_t         w_stateNext;
  logic [CREDIT_W-1:0] r_credit;
  logic [PEND_W-1:0]   r_pending;
  logic                r_coinReject;
  logic                r_refundValid;
  logic [CREDIT_W-1:0] r_refundAmt;

  logic [CREDIT_W:0]   w_val;
  logic [CREDIT_W:0]   w_sum;
  logic                w_coinIn;
  logic                w_ackEff;
  logic                w_vendReq;
  logic                w_reject;
  logic                w_vend;
  logic [CREDIT_W-1:0] w_creditAfter;
  logic [CREDIT_W-1:0] w_creditNext;
  logic [PEND_W-1:0]   w_pendingNext;

  coin_value_decode #(
    .CREDIT_W   (CREDIT_W),
    .VAL_CIRCLE (VAL_CIRCLE),
    .VAL_TRI    (VAL_TRI),
    .VAL_PENT   (VAL_PENT)
  ) u_decode (
    .i_coin (bus.coin),
    .o_val  (w_val)
  );

  // A full queue only blocks a vending coin if no slot frees up this same cycle.
  always_comb begin
    w_coinIn      = (bus.coin != COIN_NONE);
    w_ackEff      = bus.drop_ack && (r_state == VS_VEND);
    w_sum         = {1'b0, r_credit} + w_val;
    w_vendReq     = w_coinIn && (w_sum >= PRICE_X);
    w_reject      = w_vendReq && (r_pending == MAX_P) && !w_ackEff;
    w_vend        = w_vendReq && !w_reject;
    w_creditAfter = r_credit;
    if (w_coinIn && !w_reject) begin
      if (w_vendReq) w_creditAfter = CREDIT_W'(w_sum - PRICE_X);
      else           w_creditAfter = CREDIT_W'(w_sum);
    end
    w_creditNext  = bus.cancel ? '0 : w_creditAfter;
    w_pendingNext = r_pending + PEND_W'(w_vend) - PEND_W'(w_ackEff);
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      VS_IDLE: if (w_vend) w_stateNext = VS_VEND;
      VS_VEND: if (w_ackEff && !w_vend && (r_pending == ONE_P)) w_stateNext = VS_IDLE;
      default: w_stateNext = VS_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= VS_IDLE;
      r_credit      <= '0;
      r_pending     <= '0;
      r_coinReject  <= 1'b0;
      r_refundValid <= 1'b0;
      r_refundAmt   <= '0;
    end else begin
      r_state       <= w_stateNext;
      r_credit      <= w_creditNext;
      r_pending     <= w_pendingNext;
      r_coinReject  <= w_reject;
      r_refundValid <= bus.cancel;
      if (bus.cancel) r_refundAmt <= w_creditAfter;
    end
  end

  assign bus.credit       = r_credit;
  assign bus.drop         = (r_state == VS_VEND);
  assign bus.pending      = r_pending;
  assign bus.coin_reject  = r_coinReject;
  assign bus.refund_valid = r_refundValid;
  assign bus.refund_amt   = r_refundAmt;

endmodule

// File: tb/tb_coin_vend_ctrl.sv
// Directed self-checking bench for coin_vend_ctrl at default parameters (price 4, coins 1/3/5, queue 3).
module tb_coin_vend_ctrl;
  import vend_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  coin_vend_ctrl_if #(.CREDIT_W(4), .PEND_W(2)) bus ();

  coin_vend_ctrl #(
    .CREDIT_W   (4),
    .PRICE      (4),
    .VAL_CIRCLE (1),
    .VAL_TRI    (3),
    .VAL_PENT   (5),
    .MAX_PEND   (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs are held for exactly one rising edge, then outputs are sampled 1 time unit later.
  task automatic applyStimulus(input coin_t c, input logic cx, input logic ack);
    bus.coin     = c;
    bus.cancel   = cx;
    bus.drop_ack = ack;
    @(posedge clock);
    #1;
    bus.coin     = COIN_NONE;
    bus.cancel   = 1'b0;
    bus.drop_ack = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag, input int cr, input int pe, input int dr);
    checkOutput({tag, ".credit"},  32'(bus.credit),  32'(cr));
    checkOutput({tag, ".pending"}, 32'(bus.pending), 32'(pe));
    checkOutput({tag, ".drop"},    32'(bus.drop),    32'(dr));
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    bus.coin     = COIN_NONE;
    bus.cancel   = 1'b0;
    bus.drop_ack = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkState("rst", 0, 0, 0);
    checkOutput("rst.reject", 32'(bus.coin_reject),  0);
    checkOutput("rst.rvalid", 32'(bus.refund_valid), 0);
    checkOutput("rst.ramt",   32'(bus.refund_amt),   0);
    reset = 1'b0;

    applyStimulus(COIN_CIRCLE, 0, 0); checkState("c1", 1, 0, 0);
    applyStimulus(COIN_CIRCLE, 0, 0); checkState("c2", 2, 0, 0);
    applyStimulus(COIN_CIRCLE, 0, 0); checkState("c3", 3, 0, 0);
    applyStimulus(COIN_CIRCLE, 0, 0); checkState("c4", 0, 1, 1);
    applyStimulus(COIN_NONE,   0, 1); checkState("ack1", 0, 0, 0);

    applyStimulus(COIN_PENT,   0, 0); checkState("pent", 1, 1, 1);
    applyStimulus(COIN_NONE,   0, 1); checkState("ack2", 1, 0, 0);
    applyStimulus(COIN_NONE,   0, 1); checkState("ackIdle", 1, 0, 0);

    applyStimulus(COIN_TRI,    0, 0); checkState("fill1", 0, 1, 1);
    applyStimulus(COIN_PENT,   0, 0); checkState("fill2", 1, 2, 1);
    applyStimulus(COIN_TRI,    0, 0); checkState("fill3", 0, 3, 1);
    applyStimulus(COIN_PENT,   0, 0); checkState("full", 0, 3, 1);
    checkOutput("full.reject", 32'(bus.coin_reject), 1);
    applyStimulus(COIN_CIRCLE, 0, 0); checkState("fullSmall", 1, 3, 1);
    checkOutput("fullSmall.reject", 32'(bus.coin_reject), 0);

    applyStimulus(COIN_NONE,   1, 0); checkState("cancel1", 0, 3, 1);
    checkOutput("cancel1.rvalid", 32'(bus.refund_valid), 1);
    checkOutput("cancel1.ramt",   32'(bus.refund_amt),   1);
    applyStimulus(COIN_PENT,   0, 1); checkState("fullAck", 1, 3, 1);
    checkOutput("fullAck.reject", 32'(bus.coin_reject), 0);
    checkOutput("fullAck.rvalid", 32'(bus.refund_valid), 0);

    applyStimulus(COIN_CIRCLE, 0, 0); checkState("cr2", 2, 3, 1);
    applyStimulus(COIN_CIRCLE, 1, 0); checkState("cancel2", 0, 3, 1);
    checkOutput("cancel2.rvalid", 32'(bus.refund_valid), 1);
    checkOutput("cancel2.ramt",   32'(bus.refund_amt),   3);
    applyStimulus(COIN_NONE,   0, 0);
    checkOutput("hold.rvalid", 32'(bus.refund_valid), 0);
    checkOutput("hold.ramt",   32'(bus.refund_amt),   3);
    applyStimulus(COIN_NONE,   1, 0);
    checkOutput("cancel0.rvalid", 32'(bus.refund_valid), 1);
    checkOutput("cancel0.ramt",   32'(bus.refund_amt),   0);

    applyStimulus(COIN_NONE,   0, 1); checkState("drain1", 0, 2, 1);
    applyStimulus(COIN_NONE,   0, 1); checkState("drain2", 0, 1, 1);
    applyStimulus(COIN_TRI,    0, 0); checkState("tri", 3, 1, 1);
    applyStimulus(COIN_CIRCLE, 0, 1); checkState("vendAck", 0, 1, 1);
    applyStimulus(COIN_NONE,   0, 1); checkState("drain3", 0, 0, 0);

    applyStimulus(COIN_PENT,   0, 0); checkState("pre1", 1, 1, 1);
    applyStimulus(COIN_PENT,   0, 0); checkState("pre2", 2, 2, 1);
    applyStimulus(COIN_NONE,   1, 0);
    reset = 1'b1;
    #2;
    checkState("midRst", 0, 0, 0);
    checkOutput("midRst.rvalid", 32'(bus.refund_valid), 0);
    checkOutput("midRst.ramt",   32'(bus.refund_amt),   0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    applyStimulus(COIN_TRI,    0, 0); checkState("postRst", 3, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
